// File: rtl/tt_memop_issue_arb.sv
// Issues vector load/store uops into the single memop execution path, one instruction at a time,
// with store-buffer credit tracking. Optional build macro MEMOP_ARB_LD_PRIO_EN: fixed load priority in IDLE.
module tt_memop_issue_arb #(
   parameter int CREDIT_W     = 6,
   parameter int INIT_CREDITS = 32
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_ld_rts,
   input  logic                i_st_rts,
   input  logic                i_ld_last_uop,
   input  logic                i_st_last_uop,
   output logic                o_ld_rtr,
   output logic                o_st_rtr,
   output logic                o_id_ex_rts,
   input  logic                i_ex_rtr,
   output logic                o_load,
   output logic                o_store,
   output logic                o_last_uop,
   input  logic                i_memop_busy,
   input  logic                i_completed_valid,
   input  logic                i_st_credit_ret,
   output logic [CREDIT_W-1:0] o_st_credits,
   output logic                o_credit_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LD_ACT    = 2'd1,
      ST_ACT    = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] CRED_INIT = CREDIT_W'(INIT_CREDITS);
   localparam logic [CREDIT_W-1:0] CRED_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};
   localparam logic [CREDIT_W-1:0] CRED_ZERO = {CREDIT_W{1'b0}};

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic                credit_err_q, credit_err_d;
`ifndef MEMOP_ARB_LD_PRIO_EN
   logic                last_grant_st_q, last_grant_st_d;
`endif

   logic credit_avail;
   logic ld_elig;
   logic st_elig;
   logic pick_ld;
   logic pick_st;
   logic sel_ld;
   logic sel_st;
   logic fwd_ld;
   logic fwd_st;
   logic fwd_last;
   logic xfer;
   logic st_xfer;

   assign credit_avail = (credits_q != CRED_ZERO);

   // IDLE arbitration; busy memop FSM blocks any new grant
   always_comb begin
      ld_elig = i_ld_rts & ~i_memop_busy;
      st_elig = i_st_rts & credit_avail & ~i_memop_busy;
`ifdef MEMOP_ARB_LD_PRIO_EN
      pick_ld = ld_elig;
`else
      if (ld_elig && st_elig) begin
         pick_ld = last_grant_st_q;
      end else begin
         pick_ld = ld_elig;
      end
`endif
      pick_st = st_elig & ~pick_ld;
   end

   // Source selected for forwarding this cycle
   always_comb begin
      sel_ld = 1'b0;
      sel_st = 1'b0;
      case (state_q)
         IDLE: begin
            sel_ld = pick_ld;
            sel_st = pick_st;
         end
         LD_ACT:    sel_ld = i_ld_rts;
         ST_ACT:    sel_st = i_st_rts & credit_avail;
         WAIT_DONE: begin
            sel_ld = 1'b0;
            sel_st = 1'b0;
         end
         default: begin
            sel_ld = 1'b0;
            sel_st = 1'b0;
         end
      endcase
   end

   // Valid/ready outputs are forced low during the reset cycle
   assign fwd_ld   = sel_ld & i_reset_n;
   assign fwd_st   = sel_st & i_reset_n;
   assign fwd_last = (fwd_ld & i_ld_last_uop) | (fwd_st & i_st_last_uop);
   assign xfer     = (fwd_ld | fwd_st) & i_ex_rtr;
   assign st_xfer  = fwd_st & i_ex_rtr;

   assign o_id_ex_rts = fwd_ld | fwd_st;
   assign o_load      = fwd_ld;
   assign o_store     = fwd_st;
   assign o_last_uop  = fwd_last;
   assign o_ld_rtr    = fwd_ld & i_ex_rtr;
   assign o_st_rtr    = st_xfer;

   // Instruction lock / commit-wait next state
   always_comb begin
      state_d = state_q;
`ifndef MEMOP_ARB_LD_PRIO_EN
      last_grant_st_d = last_grant_st_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_ld || pick_st) begin
`ifndef MEMOP_ARB_LD_PRIO_EN
               last_grant_st_d = pick_st;
`endif
               if (xfer && fwd_last) begin
                  state_d = WAIT_DONE;
               end else if (pick_ld) begin
                  state_d = LD_ACT;
               end else begin
                  state_d = ST_ACT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LD_ACT, ST_ACT: begin
            if (xfer && fwd_last) begin
               state_d = WAIT_DONE;
            end else begin
               state_d = state_q;
            end
         end
         WAIT_DONE: begin
            if (i_completed_valid) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!i_reset_n) begin
         state_d = IDLE;
`ifndef MEMOP_ARB_LD_PRIO_EN
         last_grant_st_d = 1'b1;
`endif
      end else begin
         state_d = state_d;
      end
   end

   // Store credits: a return while already full saturates and flags an error
   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      if (!i_reset_n) begin
         credits_d    = CRED_INIT;
         credit_err_d = 1'b0;
      end else if (st_xfer && !i_st_credit_ret) begin
         credits_d = credits_q - CRED_ONE;
      end else if (!st_xfer && i_st_credit_ret) begin
         if (credits_q >= CRED_INIT) begin
            credits_d    = CRED_INIT;
            credit_err_d = 1'b1;
         end else begin
            credits_d = credits_q + CRED_ONE;
         end
      end else begin
         credits_d = credits_q;
      end
   end

   // State registers (reset folded into the _d logic)
   always_ff @(posedge i_clk) begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
`ifndef MEMOP_ARB_LD_PRIO_EN
      last_grant_st_q <= last_grant_st_d;
`endif
   end

   assign o_st_credits = credits_q;
   assign o_credit_err = credit_err_q;

endmodule

// File: tb/tb_tt_memop_issue_arb.sv
// Self-checking bench for tt_memop_issue_arb: vector table, directed corner sequences,
// and randomized stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_tt_memop_issue_arb;

   localparam int CREDIT_W     = 6;
   localparam int INIT_CREDITS = 32;
`ifdef MEMOP_ARB_LD_PRIO_EN
   localparam bit LD_PRIO = 1'b1;
`else
   localparam bit LD_PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ld_rts = 1'b0, st_rts = 1'b0, ld_last = 1'b0, st_last = 1'b0;
   logic ex_rtr = 1'b0, busy = 1'b0, cv = 1'b0, cret = 1'b0;
   logic ld_rtr, st_rtr, id_ex_rts, load, store, last_uop, credit_err;
   logic [CREDIT_W-1:0] credits;

   always #5 clk = ~clk;

   tt_memop_issue_arb #(.CREDIT_W(CREDIT_W), .INIT_CREDITS(INIT_CREDITS)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_ld_rts(ld_rts), .i_st_rts(st_rts),
      .i_ld_last_uop(ld_last), .i_st_last_uop(st_last),
      .o_ld_rtr(ld_rtr), .o_st_rtr(st_rtr),
      .o_id_ex_rts(id_ex_rts), .i_ex_rtr(ex_rtr),
      .o_load(load), .o_store(store), .o_last_uop(last_uop),
      .i_memop_busy(busy), .i_completed_valid(cv), .i_st_credit_ret(cret),
      .o_st_credits(credits), .o_credit_err(credit_err)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Behavioural model: m_own = 0 free, 1 load instruction owns the path,
   // 2 store instruction owns it, 3 last uop sent and waiting for commit.
   int m_own     = 0;
   bit m_last_st = 1'b1;
   int m_cred    = INIT_CREDITS;
   bit m_err     = 1'b0;
   bit x_ld      = 1'b0;
   bit x_st      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // One clock: compare at negedge (optional), then advance the model at posedge.
   task automatic tick(input bit use_model);
      int src;
      bit le, se, e_last, xfer;
      @(negedge clk);
      src = 0;
      if (rst_n) begin
         if (m_own == 0) begin
            le = ld_rts && !busy;
            se = st_rts && (m_cred > 0) && !busy;
            if (le && se) src = (LD_PRIO || m_last_st) ? 1 : 2;
            else if (le) src = 1;
            else if (se) src = 2;
         end else if (m_own == 1) begin
            src = ld_rts ? 1 : 0;
         end else if (m_own == 2) begin
            src = (st_rts && m_cred > 0) ? 2 : 0;
         end
      end
      e_last = (src == 1) ? ld_last : ((src == 2) ? st_last : 1'b0);
      xfer   = (src != 0) && ex_rtr;
      if (use_model) begin
         chk("rts",    id_ex_rts, 32'(src != 0));
         chk("load",   load,      32'(src == 1));
         chk("store",  store,     32'(src == 2));
         chk("last",   last_uop,  32'(e_last));
         chk("ld_rtr", ld_rtr,    32'(xfer && src == 1));
         chk("st_rtr", st_rtr,    32'(xfer && src == 2));
         chk("cred",   credits,   m_cred);
         chk("err",    credit_err, 32'(m_err));
      end
      @(posedge clk);
      x_ld = xfer && (src == 1);
      x_st = xfer && (src == 2);
      if (!rst_n) begin
         m_own = 0; m_last_st = 1'b1; m_cred = INIT_CREDITS; m_err = 1'b0;
      end else begin
         m_cred = m_cred + int'(cret) - int'(x_st);
         if (m_cred > INIT_CREDITS) begin
            m_cred = INIT_CREDITS;
            m_err  = 1'b1;
         end
         if (m_own == 0 && src != 0) begin
            m_last_st = (src == 2);
            m_own     = (xfer && e_last) ? 3 : src;
         end else if ((m_own == 1 || m_own == 2) && xfer && e_last) begin
            m_own = 3;
         end else if (m_own == 3 && cv) begin
            m_own = 0;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      ld_rts = 1'b0; st_rts = 1'b0; ld_last = 1'b0; st_last = 1'b0;
      ex_rtr = 1'b0; busy = 1'b0; cv = 1'b0; cret = 1'b0;
   endtask

   task automatic do_reset(input bit use_model);
      rst_n = 1'b0;
      clear_inputs();
      tick(use_model);
      tick(use_model);
      rst_n = 1'b1;
   endtask

   // Issue an n-uop store instruction and commit it.
   task automatic run_store(input int n);
      int done, guard;
      st_rts = 1'b1; ex_rtr = 1'b1; done = 0; guard = 0;
      while (done < n && guard < 400) begin
         st_last = (done == n - 1);
         tick(1);
         if (x_st) done++;
         guard++;
      end
      chk("store_issue_count", done, n);
      st_rts = 1'b0; st_last = 1'b0; cv = 1'b1;
      tick(1);
      cv = 1'b0;
   endtask

   typedef struct {
      logic [7:0] in;    // {ld_rts, ld_last, st_rts, st_last, ex_rtr, busy, cv, cret}
      logic [5:0] exp;   // {rts, load, store, last, ld_rtr, st_rtr}
      int         cred;
   } vec_t;

   localparam logic [5:0] V9_EXP = LD_PRIO ? 6'b110110 : 6'b101101;
   localparam int         C10    = LD_PRIO ? 31 : 30;

   vec_t tbl[12];
   int   order[$];
   int   ld_cnt, st_cnt, cnt;

   initial begin
      tbl[0]  = '{8'b1100_1000, 6'b110110, 32};  // single load, same-cycle forward
      tbl[1]  = '{8'b1100_1000, 6'b000000, 32};  // waiting for commit
      tbl[2]  = '{8'b0000_0010, 6'b000000, 32};  // commit
      tbl[3]  = '{8'b0011_1000, 6'b101101, 32};  // single store
      tbl[4]  = '{8'b0010_0010, 6'b000000, 31};  // commit, credit consumed
      tbl[5]  = '{8'b1010_0000, 6'b110000, 31};  // both rts, last grant store -> load, no transfer
      tbl[6]  = '{8'b0010_1000, 6'b000000, 31};  // load locked, store ignored
      tbl[7]  = '{8'b1100_1000, 6'b110110, 31};  // locked load finishes
      tbl[8]  = '{8'b0000_0010, 6'b000000, 31};
      tbl[9]  = '{8'b1111_1000, V9_EXP,    31};  // both eligible after a load grant
      tbl[10] = '{8'b0000_0000, 6'b000000, C10}; // no commit yet
      tbl[11] = '{8'b0000_0010, 6'b000000, C10};

      do_reset(1'b0);
      #1;
      chk("reset_cred",   credits, INIT_CREDITS);
      chk("reset_err",    credit_err, 0);
      chk("reset_rts",    id_ex_rts, 0);
      chk("reset_ld_rtr", ld_rtr, 0);
      chk("reset_st_rtr", st_rtr, 0);

      for (int i = 0; i < 12; i++) begin
         {ld_rts, ld_last, st_rts, st_last, ex_rtr, busy, cv, cret} = tbl[i].in;
         #3;
         chk($sformatf("tbl%0d_rts", i),    id_ex_rts, tbl[i].exp[5]);
         chk($sformatf("tbl%0d_load", i),   load,      tbl[i].exp[4]);
         chk($sformatf("tbl%0d_store", i),  store,     tbl[i].exp[3]);
         chk($sformatf("tbl%0d_last", i),   last_uop,  tbl[i].exp[2]);
         chk($sformatf("tbl%0d_ld_rtr", i), ld_rtr,    tbl[i].exp[1]);
         chk($sformatf("tbl%0d_st_rtr", i), st_rtr,    tbl[i].exp[0]);
         chk($sformatf("tbl%0d_cred", i),   credits,   tbl[i].cred);
         tick(1'b0);
      end

      // Contention: 3-uop instructions from both sources
      do_reset(1'b1);
      ld_rts = 1'b1; st_rts = 1'b1; ex_rtr = 1'b1; ld_cnt = 0; st_cnt = 0;
      for (int c = 0; c < 60 && order.size() < 3; c++) begin
         ld_last = (ld_cnt == 2); st_last = (st_cnt == 2); cv = (m_own == 3);
         tick(1'b1);
         if (x_ld) begin
            if (ld_cnt == 2) begin order.push_back(1); ld_cnt = 0; end else ld_cnt++;
         end
         if (x_st) begin
            if (st_cnt == 2) begin order.push_back(2); st_cnt = 0; end else st_cnt++;
         end
      end
      chk("cont_count", order.size(), 3);
      chk("cont_first",  (order.size() > 0) ? order[0] : 0, 1);
      chk("cont_second", (order.size() > 1) ? order[1] : 0, LD_PRIO ? 1 : 2);
      chk("cont_third",  (order.size() > 2) ? order[2] : 0, 1);

      // Lock hold across an execute stall
      do_reset(1'b1);
      ld_rts = 1'b1; ex_rtr = 1'b1;
      tick(1'b1);
      ex_rtr = 1'b0; st_rts = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(1'b1);
         chk("lock_st_rtr", st_rtr, 0);
         chk("lock_load",   load, 1);
      end
      ex_rtr = 1'b1; ld_last = 1'b1;
      #3;
      chk("lock_resume_ld_rtr", ld_rtr, 1);
      chk("lock_resume_st_rtr", st_rtr, 0);
      tick(1'b1);
      clear_inputs();

      // Credit starvation: drain to 2, then a 4-uop store
      do_reset(1'b1);
      run_store(30);
      chk("drain_cred", credits, 2);
      st_rts = 1'b1; ex_rtr = 1'b1; cnt = 0;
      for (int c = 0; c < 6; c++) begin
         st_last = (cnt == 3);
         tick(1'b1);
         if (x_st) cnt++;
      end
      chk("starve_issued", cnt, 2);
      chk("starve_rts", id_ex_rts, 0);
      chk("starve_cred", credits, 0);
      cret = 1'b1;
      for (int c = 0; c < 2; c++) begin
         st_last = (cnt == 3);
         tick(1'b1);
         if (x_st) cnt++;
      end
      cret = 1'b0;
      for (int c = 0; c < 4 && cnt < 4; c++) begin
         st_last = (cnt == 3);
         tick(1'b1);
         if (x_st) cnt++;
      end
      chk("refill_issued", cnt, 4);
      chk("refill_cred", credits, 0);
      clear_inputs(); cv = 1'b1;
      tick(1'b1);
      cv = 1'b0;

      // Simultaneous consume and return at 5 credits
      do_reset(1'b1);
      run_store(27);
      chk("five_cred", credits, 5);
      st_rts = 1'b1; st_last = 1'b1; ex_rtr = 1'b1; cret = 1'b1;
      #3;
      chk("five_st_rtr", st_rtr, 1);
      tick(1'b1);
      chk("five_cred_after", credits, 5);
      clear_inputs(); cv = 1'b1;
      tick(1'b1);
      cv = 1'b0;

      // Return while full
      do_reset(1'b1);
      cret = 1'b1;
      tick(1'b1);
      cret = 1'b0;
      chk("full_ret_cred", credits, 32);
      chk("full_ret_err", credit_err, 1);
      tick(1'b1);
      tick(1'b1);
      chk("err_sticky", credit_err, 1);

      // Busy memop blocks grants
      do_reset(1'b1);
      busy = 1'b1; ld_rts = 1'b1; st_rts = 1'b1; ex_rtr = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(1'b1);
         chk("busy_rts", id_ex_rts, 0);
      end
      busy = 1'b0;
      tick(1'b1);
      clear_inputs();

      // Reset in the middle of a store instruction
      do_reset(1'b1);
      st_rts = 1'b1; ex_rtr = 1'b1;
      tick(1'b1);
      tick(1'b1);
      chk("mid_cred", credits, 30);
      rst_n = 1'b0;
      #3;
      chk("rst_rts", id_ex_rts, 0);
      chk("rst_st_rtr", st_rtr, 0);
      chk("rst_ld_rtr", ld_rtr, 0);
      tick(1'b1);
      rst_n = 1'b1; st_rts = 1'b0;
      chk("rst_cred", credits, INIT_CREDITS);
      ld_rts = 1'b1; ld_last = 1'b1;
      #3;
      chk("rst_unlocked_ld_rtr", ld_rtr, 1);
      tick(1'b1);
      clear_inputs(); cv = 1'b1;
      tick(1'b1);
      cv = 1'b0;

      // Randomized run against the model
      do_reset(1'b1);
      for (int c = 0; c < 3000; c++) begin
         ld_rts  = ($urandom_range(0, 1) == 0);
         st_rts  = ($urandom_range(0, 1) == 0);
         ld_last = ($urandom_range(0, 2) == 0);
         st_last = ($urandom_range(0, 2) == 0);
         ex_rtr  = ($urandom_range(0, 3) != 0);
         busy    = ($urandom_range(0, 7) == 0);
         cret    = ($urandom_range(0, 3) == 0);
         cv      = (m_own == 3) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         rst_n   = ($urandom_range(0, 299) != 0);
         tick(1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/tt_memop_issue_arb.md
# tt_memop_issue_arb

Arbitrates vector load and store uop streams from the decode/issue side into the single VPU memop execution path and its memop FSM. Grants one memory instruction at a time and holds the grant for all of that instruction's uops. Blocks new grants until the previous memop commits. Tracks store-data credits toward the OVI store buffer so store uops never overrun it.

## Interface
- CREDIT_W, 6: width of the store-credit counter.
- INIT_CREDITS, 32: credits loaded at reset; must be ≤ 2^CREDIT_W − 1.

- i_clk  in  1  clock
- i_reset_n  in  1  reset; synchronous, active-low
- i_ld_rts / i_st_rts  in  1  load/store source has a uop valid
- i_ld_last_uop / i_st_last_uop  in  1  the presented uop is the last of its instruction
- o_ld_rtr / o_st_rtr  out  1  uop accepted from the load/store source this cycle
- o_id_ex_rts  out  1  uop valid toward the execute stage
- i_ex_rtr  in  1  execute stage ready
- o_load / o_store  out  1  type of the forwarded uop (one-hot when o_id_ex_rts)
- o_last_uop  out  1  forwarded last-uop flag
- i_memop_busy  in  1  memop FSM past PREPARE (its OVI stall)
- i_completed_valid  in  1  memop FSM commit pulse
- i_st_credit_ret  in  1  one store-buffer entry freed
- o_st_credits  out  CREDIT_W  current store credits
- o_credit_err  out  1  sticky: a credit was returned while the counter was at INIT_CREDITS

## Operation
- States: IDLE, LD_ACT, ST_ACT, WAIT_DONE. Reset: IDLE, last_grant=store, o_st_credits=INIT_CREDITS, o_credit_err=0.
- Eligibility:
  - Load is eligible when i_ld_rts=1.
  - Store is eligible when i_st_rts=1 and credits>0.
  - Nothing is eligible while i_memop_busy=1.
- IDLE arbitration:
  - If both are eligible, round-robin picks the source opposite last_grant.
  - The pick is combinational and is forwarded in the same cycle.
  - last_grant updates to the pick.
- Next state from IDLE, with a pick:
  - If it transfers with last_uop=1 → WAIT_DONE.
  - Otherwise → LD_ACT or ST_ACT. The selection is locked even if no transfer occurred.
- LD_ACT/ST_ACT:
  - Forward only the locked source; the other source's rtr is held 0.
  - Store uops additionally require credits>0. At 0 credits, o_id_ex_rts=0.
  - A transfer with last_uop=1 → WAIT_DONE.
- WAIT_DONE:
  - No rts forwarded.
  - i_completed_valid → IDLE. A new grant is allowed in the next cycle.
- Transfer condition: o_id_ex_rts && i_ex_rtr. The source rtr equals the transfer qualified by the locked source.
- o_load, o_store and o_last_uop mirror the locked source. They are 0 when o_id_ex_rts=0.
- Credits:
  - Each store transfer decrements the counter.
  - i_st_credit_ret increments it.
  - Both in the same cycle → unchanged.
  - A return at INIT_CREDITS saturates the counter and sets o_credit_err. o_credit_err clears only on reset.
- i_completed_valid outside WAIT_DONE is ignored.

## Timing
- Grant-to-forward latency is 0 cycles (combinational). State and credit updates take effect on the next edge.
- Single-uop instruction: IDLE → WAIT_DONE in 1 cycle.
- Minimum IDLE-to-IDLE time is 2 cycles (transfer cycle, then the completed cycle).
- During the reset cycle all valid/ready outputs are 0. Reset in mid-instruction returns to IDLE and discards the lock and credits.
- Credit decrement is visible in the cycle after the transfer. A store at credits=1 issues once, then stalls.

## Configuration
- MEMOP_ARB_LD_PRIO_EN:
  - Defined: the IDLE arbiter uses fixed load priority, and last_grant is unused.
  - Undefined: round-robin as specified.
- Credit logic is identical in both builds.

## Test plan
- Single load: i_ld_rts=1, i_ld_last_uop=1, i_ex_rtr=1 in IDLE → o_id_ex_rts=o_load=1 and o_ld_rtr=1 in the same cycle. State goes to WAIT_DONE. i_completed_valid returns it to IDLE.
- Contention: both rts held, 3-uop instructions each, after reset → order is load (3 uops), then store (3 uops), then load. With MEMOP_ARB_LD_PRIO_EN the order is load, load.
- Lock hold: load locked after uop 1, then i_ex_rtr=0 for 4 cycles while i_st_rts=1 → o_st_rtr stays 0 and the load resumes when i_ex_rtr returns.
- Credits: INIT_CREDITS=2, 4-uop store, no returns → 2 uops issue, then o_id_ex_rts=0. Two i_st_credit_ret pulses → the remaining 2 uops issue. o_st_credits ends at 0.
- Simultaneous store transfer and credit return at credits=5 → stays 5. A return at 32 with no consumption → stays 32 and o_credit_err=1.
- Busy/reset: i_memop_busy=1 in IDLE with both rts → no grant. Reset asserted in ST_ACT mid-instruction → IDLE, credits=INIT_CREDITS, all rts/rtr=0.
